// File: rtl/proc_mem_arb_pkg.sv
// Shared types and constants for the processor memory arbiter.
// src_t  : which processor port issued a memory request
// tag_t  : per-request record kept in the in-order tag queue
package proc_mem_arb_pkg;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_t;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  // wr marks a data write so its ack can be returned with zero data.
  typedef struct packed {
    src_t src;
    logic wr;
  } tag_t;

endpackage

// File: rtl/proc_mem_arb_tagq.sv
// In-order tag queue: circular FIFO of DEPTH request tags.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enq, enq_tag    push a tag (ignored when full)
//   deq             pop the head tag (ignored when empty)
//   head            tag at the head of the queue
//   full, empty     occupancy flags
module proc_mem_arb_tagq
  import proc_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enq,
  input  tag_t enq_tag,
  input  logic deq,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = 1;
  localparam logic [PtrW:0]   CntOne  = 1;
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  tag_t            mem_q [DEPTH];
  logic            enq_ok, deq_ok;

  assign full   = (count_q == CntFull);
  assign empty  = (count_q == '0);
  assign enq_ok = enq & ~full;
  assign deq_ok = deq & ~empty;
  assign head   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (enq_ok) begin
        mem_q[wr_ptr_q] <= enq_tag;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (deq_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
      if (enq_ok && !deq_ok)      count_q <= count_q + CntOne;
      else if (!enq_ok && deq_ok) count_q <= count_q - CntOne;
    end
  end

endmodule

// File: rtl/proc_mem_arb.sv
// Two-port to one-port memory arbiter for the TinyRV1 processor.
// Merges fetch (imem) and data (dmem) requests onto one memory port, tags each
// issued request with its source, and steers in-order responses back.
// Ports: clk/rst, imemreq_*/imemresp_* fetch side, dmemreq_*/dmemresp_* data
// side, memreq_*/memresp_* merged memory side.
// Build option: define PROC_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise dmem has fixed priority over imem.
module proc_mem_arb
  import proc_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data
);

  logic full, empty, issue_ok, fire, deq;
  src_t winner;
  tag_t head, enq_tag;

`ifdef PROC_MEM_ARB_RR_EN
  src_t last_q;

  // Reset value makes imem win the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_q <= SRC_DMEM;
    else if (fire) last_q <= winner;
  end
`endif

  always_comb begin
    if (imemreq_val && dmemreq_val) begin
`ifdef PROC_MEM_ARB_RR_EN
      winner = (last_q == SRC_DMEM) ? SRC_IMEM : SRC_DMEM;
`else
      winner = SRC_DMEM;  // memory stage holds the older instruction
`endif
    end else if (dmemreq_val) begin
      winner = SRC_DMEM;
    end else begin
      winner = SRC_IMEM;
    end
  end

  // rst gating keeps every output at zero while reset is held.
  assign issue_ok   = ~full & ~rst;
  assign memreq_val = (imemreq_val | dmemreq_val) & issue_ok;
  assign fire       = memreq_val & memreq_rdy;

  assign imemreq_rdy = imemreq_val & (winner == SRC_IMEM) & memreq_rdy & issue_ok;
  assign dmemreq_rdy = dmemreq_val & (winner == SRC_DMEM) & memreq_rdy & issue_ok;

  always_comb begin
    memreq_type  = MEMREQ_READ;
    memreq_addr  = '0;
    memreq_wdata = '0;
    if (memreq_val) begin
      if (winner == SRC_DMEM) begin
        memreq_type  = dmemreq_type;
        memreq_addr  = dmemreq_addr;
        memreq_wdata = dmemreq_wdata;
      end else begin
        memreq_addr = imemreq_addr;
      end
    end
  end

  assign enq_tag.src = winner;
  assign enq_tag.wr  = (winner == SRC_DMEM) & (dmemreq_type == MEMREQ_WRITE);

  // A response against an empty queue is dropped rather than popped.
  assign deq = memresp_val & ~empty;

  proc_mem_arb_tagq #(
    .DEPTH(DEPTH)
  ) u_tagq (
    .clk    (clk),
    .rst    (rst),
    .enq    (fire),
    .enq_tag(enq_tag),
    .deq    (deq),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  assign imemresp_val  = deq & (head.src == SRC_IMEM);
  assign dmemresp_val  = deq & (head.src == SRC_DMEM);
  assign imemresp_data = imemresp_val ? memresp_data : '0;
  assign dmemresp_data = (dmemresp_val && !head.wr) ? memresp_data : '0;

`ifndef SYNTHESIS
  a_resp_with_tag : assert property (@(posedge clk) disable iff (rst) !(memresp_val && empty))
    else $error("proc_mem_arb: memory response with no outstanding request");
`endif

endmodule

// File: tb/tb_proc_mem_arb.sv
// Directed self-checking bench for proc_mem_arb (DEPTH = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_proc_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val, imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type;
  logic [31:0] dmemreq_addr, dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;
  logic        memreq_val, memreq_rdy, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  proc_mem_arb #(
    .DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imemreq_val  (imemreq_val),
    .imemreq_rdy  (imemreq_rdy),
    .imemreq_addr (imemreq_addr),
    .imemresp_val (imemresp_val),
    .imemresp_data(imemresp_data),
    .dmemreq_val  (dmemreq_val),
    .dmemreq_rdy  (dmemreq_rdy),
    .dmemreq_type (dmemreq_type),
    .dmemreq_addr (dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val (dmemresp_val),
    .dmemresp_data(dmemresp_data),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memreq_type  (memreq_type),
    .memreq_addr  (memreq_addr),
    .memreq_wdata (memreq_wdata),
    .memresp_val  (memresp_val),
    .memresp_data (memresp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    imemreq_val   = 1'b0;
    imemreq_addr  = '0;
    dmemreq_val   = 1'b0;
    dmemreq_type  = 1'b0;
    dmemreq_addr  = '0;
    dmemreq_wdata = '0;
    memreq_rdy    = 1'b0;
    memresp_val   = 1'b0;
    memresp_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    // Request pending during reset must not be issued.
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h200;
    memreq_rdy   = 1'b1;
    @(negedge clk); #1;
    check("rst_memreq_val", 32'(memreq_val), 32'd0);
    check("rst_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
    check("rst_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
    check("rst_memreq_addr", memreq_addr, 32'h0);
    check("rst_resp_val", {30'd0, imemresp_val, dmemresp_val}, 32'd0);

    // Conflict: imem read 0x0 against dmem write 0x100 / 0xDEAD, 2 cycles.
    @(negedge clk);
    rst = 1'b0;
    idle();
    imemreq_val   = 1'b1;
    imemreq_addr  = 32'h0;
    dmemreq_val   = 1'b1;
    dmemreq_type  = 1'b1;
    dmemreq_addr  = 32'h100;
    dmemreq_wdata = 32'hDEAD;
    memreq_rdy    = 1'b1;
    #1;
`ifdef PROC_MEM_ARB_RR_EN
    check("c1_imem_rdy", 32'(imemreq_rdy), 32'd1);
    check("c1_dmem_rdy", 32'(dmemreq_rdy), 32'd0);
    check("c1_addr", memreq_addr, 32'h0);
    check("c1_type", 32'(memreq_type), 32'd0);
    check("c1_wdata", memreq_wdata, 32'h0);
`else
    check("c1_imem_rdy", 32'(imemreq_rdy), 32'd0);
    check("c1_dmem_rdy", 32'(dmemreq_rdy), 32'd1);
    check("c1_addr", memreq_addr, 32'h100);
    check("c1_type", 32'(memreq_type), 32'd1);
    check("c1_wdata", memreq_wdata, 32'hDEAD);
`endif
    @(negedge clk); #1;
    check("c2_imem_rdy", 32'(imemreq_rdy), 32'd0);
    check("c2_dmem_rdy", 32'(dmemreq_rdy), 32'd1);
    check("c2_addr", memreq_addr, 32'h100);
    check("c2_wdata", memreq_wdata, 32'hDEAD);

    // Responses come back in grant order; write acks carry zero data.
    @(negedge clk);
    idle();
    memresp_val  = 1'b1;
    memresp_data = 32'h1111_1111;
    #1;
`ifdef PROC_MEM_ARB_RR_EN
    check("r1_imem_val", 32'(imemresp_val), 32'd1);
    check("r1_imem_data", imemresp_data, 32'h1111_1111);
    check("r1_dmem_val", 32'(dmemresp_val), 32'd0);
`else
    check("r1_imem_val", 32'(imemresp_val), 32'd0);
    check("r1_dmem_val", 32'(dmemresp_val), 32'd1);
    check("r1_dmem_data", dmemresp_data, 32'h0);
`endif
    @(negedge clk);
    memresp_data = 32'h2222_2222;
    #1;
    check("r2_imem_val", 32'(imemresp_val), 32'd0);
    check("r2_dmem_val", 32'(dmemresp_val), 32'd1);
    check("r2_dmem_data", dmemresp_data, 32'h0);

    // Lone fetch at 0x200, response next cycle.
    @(negedge clk);
    idle();
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h200;
    memreq_rdy   = 1'b1;
    #1;
    check("lf_memreq_val", 32'(memreq_val), 32'd1);
    check("lf_addr", memreq_addr, 32'h200);
    check("lf_type", 32'(memreq_type), 32'd0);
    check("lf_imem_rdy", 32'(imemreq_rdy), 32'd1);
    @(negedge clk);
    idle();
    memresp_val  = 1'b1;
    memresp_data = 32'h00A0_0093;
    #1;
    check("lf_resp_val", 32'(imemresp_val), 32'd1);
    check("lf_resp_data", imemresp_data, 32'h00A0_0093);
    check("lf_dresp_val", 32'(dmemresp_val), 32'd0);

    // Lone data load: load data is passed through.
    @(negedge clk);
    idle();
    dmemreq_val  = 1'b1;
    dmemreq_addr = 32'h300;
    memreq_rdy   = 1'b1;
    #1;
    check("ld_dmem_rdy", 32'(dmemreq_rdy), 32'd1);
    check("ld_type", 32'(memreq_type), 32'd0);
    @(negedge clk);
    idle();
    memresp_val  = 1'b1;
    memresp_data = 32'hCAFE_F00D;
    #1;
    check("ld_resp_val", 32'(dmemresp_val), 32'd1);
    check("ld_resp_data", dmemresp_data, 32'hCAFE_F00D);

    // Full: four fetches with no responses, then the fifth is blocked.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h700 + 32'(4 * i);
      memreq_rdy   = 1'b1;
      #1;
      check($sformatf("fill%0d_rdy", i), 32'(imemreq_rdy), 32'd1);
    end
    // Dequeue in the same cycle does not unblock issue.
    @(negedge clk);
    memresp_val  = 1'b1;
    memresp_data = 32'hAAAA_0000;
    #1;
    check("full_memreq_val", 32'(memreq_val), 32'd0);
    check("full_imem_rdy", 32'(imemreq_rdy), 32'd0);
    check("full_resp_val", 32'(imemresp_val), 32'd1);
    @(negedge clk);
    memresp_val = 1'b0;
    #1;
    check("resume_memreq_val", 32'(memreq_val), 32'd1);
    check("resume_imem_rdy", 32'(imemreq_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      memresp_val  = 1'b1;
      memresp_data = 32'hAAAA_0001 + 32'(i);
      #1;
      check($sformatf("drain%0d_val", i), 32'(imemresp_val), 32'd1);
      check($sformatf("drain%0d_data", i), imemresp_data, 32'hAAAA_0001 + 32'(i));
    end

    // Backpressure: dmem held for 3 cycles must not be accepted or tagged.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      dmemreq_val  = 1'b1;
      dmemreq_addr = 32'h500;
      #1;
      check($sformatf("bp%0d_dmem_rdy", i), 32'(dmemreq_rdy), 32'd0);
      check($sformatf("bp%0d_memreq_val", i), 32'(memreq_val), 32'd1);
    end
    @(negedge clk);
    idle();
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h600;
    memreq_rdy   = 1'b1;
    #1;
    check("bp_fetch_rdy", 32'(imemreq_rdy), 32'd1);
    // If a dmem tag had leaked in, this response would go to dmem.
    @(negedge clk);
    idle();
    memresp_val  = 1'b1;
    memresp_data = 32'h7777_7777;
    #1;
    check("bp_resp_imem", 32'(imemresp_val), 32'd1);
    check("bp_resp_dmem", 32'(dmemresp_val), 32'd0);

    // Reset mid-flight with two fetches outstanding.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle();
      imemreq_val  = 1'b1;
      imemreq_addr = 32'h400 + 32'(4 * i);
      memreq_rdy   = 1'b1;
    end
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_memreq_val", 32'(memreq_val), 32'd0);
    check("mid_rst_imem_rdy", 32'(imemreq_rdy), 32'd0);
    check("mid_rst_addr", memreq_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    memresp_val  = 1'b1;
    memresp_data = 32'h5555_5555;
    #1;
    check("drop_imem_val", 32'(imemresp_val), 32'd0);
    check("drop_dmem_val", 32'(dmemresp_val), 32'd0);
    check("drop_imem_data", imemresp_data, 32'h0);
    #1;
    memresp_val = 1'b0;
    @(negedge clk);
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h800;
    memreq_rdy   = 1'b1;
    #1;
    check("post_rst_issue", 32'(memreq_val), 32'd1);

    @(negedge clk);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
